// File: rtl/mem_if_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_if_pkg
//  Description : Shared definitions for the cache <-> main-memory interface.
//                Imported by both the cache controller and the memory
//                responder so that both ends agree on widths and states.
//  Contents    : ADDR_W, DATA_W, LATENCY_MAX, mem_state_t, mem_word_t
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_if_pkg;

  localparam int ADDR_W      = 5;   // block address = {tag[3:0], index}
  localparam int DATA_W      = 4;   // one block is one data word
  localparam int LATENCY_MAX = 15;  // largest access latency the counter holds

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  typedef logic [3:0] mem_word_t;

endpackage : mem_if_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : (2**ADDR_W) x DATA_W backing store. Asynchronous reset
//                preloads every word with the low bits of its own address.
//                One synchronous write port and one registered read port
//                sharing a single address.
//  Ports       : clock_i    in   system clock, rising edge
//                reset_n_i  in   asynchronous active-low reset
//                we_i       in   write enable
//                re_i       in   read enable (loads the read register)
//                addr_i     in   word address
//                wdata_i    in   write data
//                rdata_o    out  registered read data, holds between reads
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
  import mem_if_pkg::*;
#(
  parameter int ADDR_W = mem_if_pkg::ADDR_W,
  parameter int DATA_W = mem_if_pkg::DATA_W
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Reset restores the preload pattern, so a write that was still in
  // flight when reset hit can never survive.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem_q[a] <= DATA_W'(a);
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule : mem_array
`default_nettype wire

// File: rtl/main_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : main_memory_responder
//  Description : Main-memory side of the cache <-> memory interface. Serves
//                line-fill reads and dirty write-backs with a fixed access
//                latency followed by a one-cycle ack. Requests are sampled
//                only in IDLE; a write wins over a simultaneous read.
//  Options     : MEM_STATS_EN - adds rd_count_o / wr_count_o ack counters.
//  Parameters  : ADDR_W (5), DATA_W (4), LATENCY (3, legal 1..15)
//  Ports       : clock_i     in   system clock, rising edge
//                reset_n_i   in   asynchronous active-low reset
//                rd_req_i    in   line-fill request, held until ack
//                wr_req_i    in   write-back request, held until ack
//                addr_i      in   block address {tag[3:0], index}
//                wdata_i     in   write-back data
//                rdata_o     out  read data, valid in a read ack cycle
//                ack_o       out  one-cycle completion pulse
//                busy_o      out  request captured and not yet acked
//                rd_count_o  out  read acks issued, wraps (MEM_STATS_EN)
//                wr_count_o  out  write acks issued, wraps (MEM_STATS_EN)
//  Revision    : 1.0 - initial release
// ============================================================================
module main_memory_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = mem_if_pkg::ADDR_W,
  parameter int DATA_W  = mem_if_pkg::DATA_W,
  parameter int LATENCY = 3
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic              busy_o
`ifdef MEM_STATS_EN
  ,
  output logic [7:0]        rd_count_o,
  output logic [7:0]        wr_count_o
`endif
);

  localparam int CNT_W = 4;  // holds LATENCY_MAX

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              w_mem_we;
  logic              w_mem_re;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_wr_d  = op_wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    w_mem_we = 1'b0;
    w_mem_re = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req_i || rd_req_i) begin
          // Write-back precedes fill; a concurrent read stays asserted by
          // the requester and is picked up on a later IDLE cycle.
          op_wr_d = wr_req_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          // WAIT spans LATENCY+1 edges including the terminal one, which
          // puts ack LATENCY+1 edges after the capture edge.
          cnt_d   = CNT_W'(LATENCY);
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          w_mem_we = op_wr_q;
          w_mem_re = !op_wr_q;
          ack_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .we_i      (w_mem_we),
    .re_i      (w_mem_re),
    .addr_i    (addr_q),
    .wdata_i   (wdata_q),
    .rdata_o   (rdata_o)
  );

  assign ack_o  = ack_q;
  assign busy_o = busy_q;

`ifdef MEM_STATS_EN
  logic [7:0] rd_count_q;
  logic [7:0] wr_count_q;

  // The array enables fire on the same edge that raises ack, so the
  // counters step in the ack cycle itself.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_count_q <= '0;
      wr_count_q <= '0;
    end else begin
      if (w_mem_re) begin
        rd_count_q <= rd_count_q + 8'd1;
      end
      if (w_mem_we) begin
        wr_count_q <= wr_count_q + 8'd1;
      end
    end
  end

  assign rd_count_o = rd_count_q;
  assign wr_count_o = wr_count_q;
`endif

endmodule : main_memory_responder
`default_nettype wire
